// File: rtl/pc_fetch_unit.sv
// Instruction fetch: keeps one imem request in flight, buffers up to two
// fetched words for decode, and squashes in-flight/buffered work on a branch redirect.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               br_valid,
  input  logic [31:0]        br_pc,
  input  logic signed [12:0] br_incr,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_instr,
  input  logic               id_ready
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_DRAIN} state_t;

  localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_buf_pc    [BUF_DEPTH];
  logic [31:0] r_buf_instr [BUF_DEPTH];
  logic        r_head;
  logic [1:0]  r_count;

  logic [31:0] w_target;
  logic        w_push;
  logic        w_pop;
  logic        w_fire;
  logic        w_wr_idx;

  assign w_target = (br_pc + {{19{br_incr[12]}}, br_incr}) & 32'hFFFF_FFFE;
  assign w_push   = (r_state == ST_WAIT) && imem_rvalid && !br_valid;
  assign w_pop    = if_valid && id_ready;
  assign w_fire   = imem_req && imem_gnt;
  assign w_wr_idx = r_head ^ r_count[0];

  // Gated by reset_n so the request is already low while reset is held.
  assign imem_req  = reset_n && (r_state == ST_RUN) && !br_valid && (r_count < FULL_CNT);
  assign imem_addr = r_pc;
  assign if_valid  = (r_count != 2'd0);
  assign if_pc     = r_buf_pc[r_head];
  assign if_instr  = r_buf_instr[r_head];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_PC;
      r_req_pc <= 32'd0;
    end else if (br_valid) begin
      r_pc <= w_target;
      // A response landing with the redirect retires the outstanding request.
      case (r_state)
        ST_WAIT, ST_DRAIN: r_state <= imem_rvalid ? ST_RUN : ST_DRAIN;
        default:           r_state <= ST_RUN;
      endcase
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_fire) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + 32'd4;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT, ST_DRAIN: begin
          if (imem_rvalid) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else if (br_valid) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01: begin
          r_count <= r_count - 2'd1;
          r_head  <= r_head ^ 1'b1;
        end
        2'b11:   r_head  <= r_head ^ 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_buf_pc[gi]    <= 32'd0;
        r_buf_instr[gi] <= 32'd0;
      end else if (w_push && (w_wr_idx == 1'(gi))) begin
        r_buf_pc[gi]    <= r_req_pc;
        r_buf_instr[gi] <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboarded bench for pc_fetch_unit: a small imem responder feeds the DUT,
// expected {pc, instr} entries are queued on response and compared on decode pops.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic               clk;
  logic               reset_n;
  logic               br_valid;
  logic [31:0]        br_pc;
  logic signed [12:0] br_incr;
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [31:0]        imem_rdata;
  logic               if_valid;
  logic [31:0]        if_pc;
  logic [31:0]        if_instr;
  logic               id_ready;

  pc_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .br_valid(br_valid), .br_pc(br_pc), .br_incr(br_incr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .id_ready(id_ready)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  ent_t        exp_q[$];
  logic [31:0] pop_log[$];

  // imem responder state
  bit          gnt_en;
  bit          rv_en;
  int          lat;
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  bit          stale;
  logic [31:0] exp_pc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  function automatic logic [31:0] redirect(input logic [31:0] bpc, input logic [12:0] binc);
    logic [31:0] ext;
    ext = {{19{binc[12]}}, binc};
    return (bpc + ext) & 32'hFFFF_FFFE;
  endfunction

  // One clock cycle, entered and left on a falling edge.
  task automatic step(input bit br, input logic [31:0] bpc, input logic [12:0] binc, input bit rdy);
    ent_t e;
    br_valid    = br;
    br_pc       = bpc;
    br_incr     = binc;
    id_ready    = rdy;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    imem_gnt    = 1'b0;
    if (pend) begin
      if (pend_cnt <= 1 && rv_en) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
      end else if (pend_cnt > 1) begin
        pend_cnt--;
      end
    end
    #1;
    imem_gnt = gnt_en && imem_req;
    #1;
    check_eq("if_valid", {31'd0, if_valid}, {31'd0, exp_q.size() != 0});
    if (if_valid && exp_q.size() != 0) begin
      check_eq("if_pc_head", if_pc, exp_q[0].pc);
      check_eq("if_instr_head", if_instr, exp_q[0].instr);
    end
    if (imem_req) check_eq("imem_addr", imem_addr, exp_pc);
    if (if_valid && id_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      $display("[TB] pop pc=%h instr=%h (exp pc=%h instr=%h)", if_pc, if_instr, e.pc, e.instr);
      check_eq("pop_pc", if_pc, e.pc);
      check_eq("pop_instr", if_instr, e.instr);
      pop_log.push_back(if_pc);
    end
    if (br) begin
      exp_q.delete();
      exp_pc = redirect(bpc, binc);
      if (pend && !imem_rvalid) stale = 1'b1;
    end
    if (imem_rvalid) begin
      if (!br && !stale) begin
        e.pc    = pend_addr;
        e.instr = imem_rdata;
        exp_q.push_back(e);
      end
      stale = 1'b0;
      pend  = 1'b0;
    end
    if (imem_gnt) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = lat;
      exp_pc    = exp_pc + 32'd4;
    end
    @(negedge clk);
  endtask

  task automatic peek();
    br_valid    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    #1;
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 13'd0, rdy);
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    br_valid    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    id_ready    = 1'b0;
    exp_q.delete();
    pop_log.delete();
    pend   = 1'b0;
    stale  = 1'b0;
    exp_pc = RST_PC;
    gnt_en = 1'b1;
    rv_en  = 1'b1;
    lat    = 1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; br_valid = 1'b0; br_pc = 32'd0; br_incr = 13'sd0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0; id_ready = 1'b0;
    pend = 1'b0; pend_cnt = 0; pend_addr = 32'd0; stale = 1'b0; exp_pc = RST_PC;
    gnt_en = 1'b1; rv_en = 1'b1; lat = 1;
    #1;
    check_eq("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst_if_pc", if_pc, 32'd0);
    check_eq("rst_if_instr", if_instr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("rel_imem_req", {31'd0, imem_req}, 32'd1);
    check_eq("rel_imem_addr", imem_addr, RST_PC);

    // Streaming
    do_reset();
    run(8, 1'b1);
    check_eq("stream_npop", pop_log.size(), 32'd3);
    check_eq("stream_pc0", pop_log[0], 32'h0);
    check_eq("stream_pc1", pop_log[1], 32'h4);
    check_eq("stream_pc2", pop_log[2], 32'h8);

    // Backpressure
    do_reset();
    run(8, 1'b0);
    peek();
    check_eq("bp_imem_req", {31'd0, imem_req}, 32'd0);
    check_eq("bp_if_valid", {31'd0, if_valid}, 32'd1);
    check_eq("bp_if_pc", if_pc, 32'h0);
    run(6, 1'b1);
    check_eq("bp_pc0", pop_log[0], 32'h0);
    check_eq("bp_pc1", pop_log[1], 32'h4);

    // Redirect while a request is outstanding
    do_reset();
    run(3, 1'b0);
    rv_en = 1'b0;
    run(1, 1'b0);
    step(1'b1, 32'h0000_0100, -13'sd8, 1'b0);
    run(1, 1'b0);
    peek();
    check_eq("wait_br_if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("wait_br_drain_req", {31'd0, imem_req}, 32'd0);
    rv_en = 1'b1;
    run(1, 1'b0);
    peek();
    check_eq("wait_br_if_valid2", {31'd0, if_valid}, 32'd0);
    check_eq("wait_br_req", {31'd0, imem_req}, 32'd1);
    check_eq("wait_br_addr", imem_addr, 32'h0000_00F8);
    pop_log.delete();
    run(4, 1'b1);
    check_eq("wait_br_pop", pop_log[0], 32'h0000_00F8);

    // Redirect coinciding with the response
    do_reset();
    run(1, 1'b1);
    step(1'b1, 32'h0000_0020, 13'sd4, 1'b1);
    peek();
    check_eq("sim_if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("sim_req", {31'd0, imem_req}, 32'd1);
    check_eq("sim_addr", imem_addr, 32'h0000_0024);
    run(4, 1'b1);
    check_eq("sim_pop", pop_log[0], 32'h0000_0024);

    // Address wrap-around
    do_reset();
    step(1'b1, 32'hFFFF_FFFC, 13'sd8, 1'b1);
    peek();
    check_eq("wrap_req", {31'd0, imem_req}, 32'd1);
    check_eq("wrap_addr", imem_addr, 32'h0000_0004);
    run(4, 1'b1);
    check_eq("wrap_pop", pop_log[0], 32'h0000_0004);

    // Reset while waiting for a response
    do_reset();
    run(3, 1'b0);
    rv_en = 1'b0;
    run(1, 1'b0);
    peek();
    check_eq("rw_pre_if_valid", {31'd0, if_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rw_imem_req", {31'd0, imem_req}, 32'd0);
    check_eq("rw_if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rw_if_pc", if_pc, 32'd0);
    check_eq("rw_if_instr", if_instr, 32'd0);
    exp_q.delete();
    pop_log.delete();
    stale  = 1'b1;
    exp_pc = RST_PC;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("rw_rel_req", {31'd0, imem_req}, 32'd1);
    check_eq("rw_rel_addr", imem_addr, RST_PC);
    gnt_en = 1'b0;
    rv_en  = 1'b1;
    run(2, 1'b1);
    gnt_en = 1'b1;
    run(5, 1'b1);
    check_eq("rw_pop", pop_log[0], RST_PC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, fetch-buffer entries (fixed at 2 in this revision).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port br_valid  in  1  execute stage resolved a branch this cycle.
REQ-006 SHALL have port br_pc  in  32  PC of the resolved branch.
REQ-007 SHALL have port br_incr  in  13 signed  increment from branch compare (4 or imm).
REQ-008 SHALL have port imem_req  out  1  instruction-memory request.
REQ-009 SHALL have port imem_addr  out  32  request address.
REQ-010 SHALL have port imem_gnt  in  1  request accepted this cycle.
REQ-011 SHALL have port imem_rvalid  in  1  response data valid.
REQ-012 SHALL have port imem_rdata  in  32  instruction word.
REQ-013 SHALL have port if_valid  out  1  decode output valid.
REQ-014 SHALL have port if_pc  out  32  PC of presented instruction.
REQ-015 SHALL have port if_instr  out  32  presented instruction.
REQ-016 SHALL have port id_ready  in  1  decode accepts this cycle.

Function
REQ-017 SHALL implement FSM states RUN (no request outstanding), WAIT (one request outstanding), DRAIN (one stale request outstanding).
REQ-018 SHALL keep at most one imem request outstanding.
REQ-019 SHALL assert imem_req only in RUN, with br_valid low, and with buffer occupancy < 2; imem_addr = pc.
REQ-020 SHALL hold imem_req and imem_addr stable until imem_gnt.
REQ-021 On imem_req && imem_gnt: SHALL latch req_pc <= pc, pc <= pc + 4 (mod 2^32), RUN -> WAIT.
REQ-022 In WAIT on imem_rvalid with br_valid low: SHALL push {req_pc, imem_rdata} into the buffer, WAIT -> RUN.
REQ-023 Redirect target SHALL be br_pc + sign-extended br_incr, modulo 2^32, with bit 0 forced to 0.
REQ-024 On br_valid: SHALL load pc <= target, flush all buffer entries, and go WAIT -> DRAIN; RUN stays RUN; DRAIN stays DRAIN.
REQ-025 br_valid and imem_rvalid in the same cycle: redirect wins; the response SHALL be discarded and the state goes to RUN.
REQ-026 In DRAIN on imem_rvalid with br_valid low: SHALL discard the data, DRAIN -> RUN.
REQ-027 SHALL drive if_valid = buffer non-empty; if_pc/if_instr = head entry; all combinational from the registers.
REQ-028 SHALL pop the head on if_valid && id_ready; push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-029 SHALL hold if_pc/if_instr stable while if_valid && !id_ready.
REQ-030 Flush SHALL take effect the cycle after br_valid (if_valid low); a pop in the flush cycle is permitted and harmless.
REQ-031 SHALL ignore imem_rvalid in RUN.
REQ-032 Buffer SHALL never overflow: occupancy + outstanding <= 2 at all times.

Reset
REQ-033 reset_n low SHALL immediately set pc=RESET_PC, state=RUN, buffer empty, req_pc=0, imem_req=0, if_valid=0, if_pc=0, if_instr=0.
REQ-034 Reset mid-transaction SHALL abandon the outstanding request; a response arriving after reset release while in RUN SHALL be ignored.
REQ-035 SHALL assert imem_req with imem_addr=RESET_PC in the first cycle after reset_n rises.

Verification
REQ-036 Bench SHALL cover streaming: gnt and rvalid one cycle later, id_ready=1 -> if_pc sequence 0x0,0x4,0x8, each paired with its rdata.
REQ-037 Bench SHALL cover backpressure: id_ready=0 -> buffer fills with 0x0,0x4; imem_req drops; if_pc holds 0x0 until id_ready=1.
REQ-038 Bench SHALL cover redirect in WAIT: br_pc=0x100, br_incr=-8 -> stale response dropped; next imem_addr=0x0F8; if_valid low in between.
REQ-039 Bench SHALL cover a simultaneous case: br_valid with imem_rvalid, br_pc=0x20, br_incr=4 -> no push; next imem_addr=0x24.
REQ-040 Bench SHALL cover wrap-around: br_pc=0xFFFF_FFFC, br_incr=8 -> imem_addr=0x0000_0004.
REQ-041 Bench SHALL cover reset asserted in WAIT -> outputs zero at once; after release imem_addr=RESET_PC, late rvalid ignored.
